// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, sequencer
// states and the datapath select codes used by the control unit and datapath.
package cpu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SLI  = 3'b001;
   localparam logic [2:0] OP_J    = 3'b010;
   localparam logic [2:0] OP_JAL  = 3'b011;
   localparam logic [2:0] OP_LW   = 3'b100;
   localparam logic [2:0] OP_SW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_ADDI = 3'b111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL, S_FAULT
   } state_t;

   localparam logic [1:0] PC_SRC_INC    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [1:0] DEST_RT = 2'b00;
   localparam logic [1:0] DEST_RD = 2'b01;
   localparam logic [1:0] DEST_R7 = 2'b10;

   localparam logic [1:0] M2R_ALU = 2'b00;
   localparam logic [1:0] M2R_MEM = 2'b01;
   localparam logic [1:0] M2R_PC1 = 2'b10;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_SHL  = 2'b10;
   localparam logic [1:0] ALU_ADDI = 2'b11;

endpackage

// File: rtl/cpu_multicycle_sequencer_if.sv
// Control bundle between the multi-cycle sequencer (master) and the
// datapath/memory side (slave).
interface cpu_multicycle_sequencer_if #(parameter int CNT_W = 16);

   logic [2:0]       cpu_opcode;
   logic             alu_zero;
   logic             imem_ready;
   logic             dmem_ready;
   logic             imem_rd;
   logic             dmem_rd;
   logic             dmem_wr;
   logic             ir_wr;
   logic             pc_wr;
   logic [1:0]       pc_src;
   logic             reg_wr;
   logic [1:0]       dest_reg;
   logic [1:0]       mem_to_reg;
   logic             alu_src;
   logic [1:0]       alu_opcode;
   logic             sign_or_zero;
   logic             instr_done;
   logic [CNT_W-1:0] instr_count;
   logic             fault;

   modport master (
      input  cpu_opcode, alu_zero, imem_ready, dmem_ready,
      output imem_rd, dmem_rd, dmem_wr, ir_wr, pc_wr, pc_src, reg_wr, dest_reg,
             mem_to_reg, alu_src, alu_opcode, sign_or_zero, instr_done,
             instr_count, fault
   );

   modport slave (
      output cpu_opcode, alu_zero, imem_ready, dmem_ready,
      input  imem_rd, dmem_rd, dmem_wr, ir_wr, pc_wr, pc_src, reg_wr, dest_reg,
             mem_to_reg, alu_src, alu_opcode, sign_or_zero, instr_done,
             instr_count, fault
   );

endinterface

// File: rtl/cpu_mem_wait_timer.sv
// Counts cycles a memory request waits for ready; expired flags the cycle the
// count sits at MEM_TIMEOUT with ready still low (a ready on that cycle wins).
module cpu_mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic ready,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

   logic [7:0] cnt_q;

   // NOTE: sequential state uses nonblocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q <= '0;
      end else if (!ready && cnt_q != LIMIT) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign expired = !ready && (cnt_q == LIMIT);

endmodule

// File: rtl/cpu_multicycle_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back, with a memory-wait timeout that faults the core.
module cpu_multicycle_sequencer
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   cpu_multicycle_sequencer_if.master bus
);

   state_t           state_q, state_d;
   logic [2:0]       op_q;
   logic [CNT_W-1:0] count_q;
   logic             wait_state;
   logic             wait_ready;
   logic             expired;

   assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
   assign wait_ready = (state_q == S_FETCH) ? bus.imem_ready :
                       wait_state           ? bus.dmem_ready : 1'b0;

   // A ready in a wait state always leaves it, so clearing on ready restarts the count for the next wait.
   cpu_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (!wait_state || wait_ready),
      .ready   (wait_ready),
      .expired (expired)
   );

   // NOTE: every variable gets a default before the case, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (bus.imem_ready) state_d = S_DECODE;
                     else if (expired)   state_d = S_FAULT;
         S_DECODE: begin
            case (bus.cpu_opcode)
               OP_ADD:          state_d = S_EXEC_R;
               OP_SLI, OP_ADDI: state_d = S_EXEC_I;
               OP_LW, OP_SW:    state_d = S_MEM_ADDR;
               OP_BEQ:          state_d = S_BRANCH;
               OP_J:            state_d = S_JUMP;
               default:         state_d = S_JAL;
            endcase
         end
         S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
         S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (bus.dmem_ready) state_d = S_WB_MEM;
                     else if (expired)   state_d = S_FAULT;
         S_MEM_WR:   if (bus.dmem_ready) state_d = S_FETCH;
                     else if (expired)   state_d = S_FAULT;
         S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL: state_d = S_FETCH;
         S_FAULT:    state_d = S_FAULT;
         default:    state_d = S_FETCH;
      endcase
   end

   // Outputs are held at their idle values while rst is high so imem_rd only rises once reset lifts.
   always_comb begin
      bus.imem_rd      = 1'b0;
      bus.dmem_rd      = 1'b0;
      bus.dmem_wr      = 1'b0;
      bus.ir_wr        = 1'b0;
      bus.pc_wr        = 1'b0;
      bus.pc_src       = PC_SRC_INC;
      bus.reg_wr       = 1'b0;
      bus.dest_reg     = DEST_RT;
      bus.mem_to_reg   = M2R_ALU;
      bus.alu_src      = 1'b0;
      bus.alu_opcode   = ALU_ADD;
      bus.sign_or_zero = 1'b1;
      bus.instr_done   = 1'b0;
      bus.fault        = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               bus.imem_rd = 1'b1;
               bus.ir_wr   = bus.imem_ready;
               bus.pc_wr   = bus.imem_ready;
            end
            S_EXEC_I: begin
               bus.alu_src = 1'b1;
               if (op_q == OP_SLI) begin
                  bus.alu_opcode   = ALU_SHL;
                  bus.sign_or_zero = 1'b0;
               end else begin
                  bus.alu_opcode   = ALU_ADDI;
               end
            end
            S_WB_ALU: begin
               bus.reg_wr     = 1'b1;
               bus.dest_reg   = (op_q == OP_ADD) ? DEST_RD : DEST_RT;
               bus.instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
               bus.alu_src    = 1'b1;
               bus.alu_opcode = ALU_ADDI;
            end
            S_MEM_RD: bus.dmem_rd = 1'b1;
            S_WB_MEM: begin
               bus.reg_wr     = 1'b1;
               bus.mem_to_reg = M2R_MEM;
               bus.instr_done = 1'b1;
            end
            S_MEM_WR: begin
               bus.dmem_wr    = 1'b1;
               bus.instr_done = bus.dmem_ready;
            end
            S_BRANCH: begin
               bus.alu_opcode = ALU_SUB;
               bus.pc_wr      = bus.alu_zero;
               bus.pc_src     = PC_SRC_BRANCH;
               bus.instr_done = 1'b1;
            end
            S_JUMP: begin
               bus.pc_wr      = 1'b1;
               bus.pc_src     = PC_SRC_JUMP;
               bus.instr_done = 1'b1;
            end
            S_JAL: begin
               bus.reg_wr     = 1'b1;
               bus.dest_reg   = DEST_R7;
               bus.mem_to_reg = M2R_PC1;
               bus.pc_wr      = 1'b1;
               bus.pc_src     = PC_SRC_JUMP;
               bus.instr_done = 1'b1;
            end
            S_FAULT: bus.fault = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         op_q    <= OP_ADD;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) op_q <= bus.cpu_opcode;
         if (bus.instr_done) count_q <= count_q + 1'b1;
      end
   end

   assign bus.instr_count = count_q;

endmodule

// File: tb/tb_cpu_multicycle_sequencer.sv
// Scoreboard bench: each scenario queues per-cycle stimulus plus expected controls,
// then the queue is drained one cycle at a time against the sequencer outputs.
module tb_cpu_multicycle_sequencer;

   localparam int CNT_W       = 4;
   localparam int MEM_TIMEOUT = 15;

   typedef struct packed {
      logic       imem_rd;
      logic       dmem_rd;
      logic       dmem_wr;
      logic       ir_wr;
      logic       pc_wr;
      logic [1:0] pc_src;
      logic       reg_wr;
      logic [1:0] dest_reg;
      logic [1:0] mem_to_reg;
      logic       alu_src;
      logic [1:0] alu_opcode;
      logic       sign_or_zero;
      logic       instr_done;
      logic       fault;
   } ctl_t;

   // ir/dr/z: 0 or 1 drive that value, 2 drives a random value
   typedef struct {
      logic       rst;
      int         ir;
      int         dr;
      int         z;
      logic       op_fix;
      logic [2:0] op;
      ctl_t       exp;
      int         cnt;
      string      name;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cpu_multicycle_sequencer_if #(.CNT_W(CNT_W)) bus();

   cpu_multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   ent_t       sb[$];
   int         errors    = 0;
   int         checks    = 0;
   int         model_cnt = -1;
   logic [2:0] cur_op    = 3'b000;

   function automatic ctl_t dflt();
      ctl_t c = '0;
      c.sign_or_zero = 1'b1;
      return c;
   endfunction

   function automatic ctl_t sample();
      ctl_t a;
      a.imem_rd      = bus.imem_rd;
      a.dmem_rd      = bus.dmem_rd;
      a.dmem_wr      = bus.dmem_wr;
      a.ir_wr        = bus.ir_wr;
      a.pc_wr        = bus.pc_wr;
      a.pc_src       = bus.pc_src;
      a.reg_wr       = bus.reg_wr;
      a.dest_reg     = bus.dest_reg;
      a.mem_to_reg   = bus.mem_to_reg;
      a.alu_src      = bus.alu_src;
      a.alu_opcode   = bus.alu_opcode;
      a.sign_or_zero = bus.sign_or_zero;
      a.instr_done   = bus.instr_done;
      a.fault        = bus.fault;
      return a;
   endfunction

   task automatic push(input string name, input ctl_t c, input int ir, input int dr,
                       input int z = 2, input logic r = 1'b0, input logic op_fix = 1'b0);
      ent_t e;
      e.rst    = r;
      e.ir     = ir;
      e.dr     = dr;
      e.z      = z;
      e.op_fix = op_fix;
      e.op     = cur_op;
      e.exp    = c;
      e.cnt    = model_cnt;
      e.name   = name;
      sb.push_back(e);
   endtask

   task automatic push_reset(input int n, input int dr0 = 2);
      for (int i = 0; i < n; i++) begin
         push("reset", dflt(), 2, (i == 0) ? dr0 : 2, 2, 1'b1);
         model_cnt = 0;
      end
   endtask

   task automatic push_fetch(input string tag, input int iw);
      ctl_t c;
      for (int i = 0; i < iw; i++) begin
         c = dflt(); c.imem_rd = 1'b1;
         push({tag, " fetch-wait"}, c, 0, 2);
      end
      c = dflt(); c.imem_rd = 1'b1; c.ir_wr = 1'b1; c.pc_wr = 1'b1;
      push({tag, " fetch"}, c, 1, 2);
      push({tag, " decode"}, dflt(), 2, 2, 2, 1'b0, 1'b1);
   endtask

   task automatic push_instr(input string tag, input logic [2:0] op, input int iw,
                             input int dw, input int z = 0);
      ctl_t c;
      cur_op = op;
      push_fetch(tag, iw);
      case (op)
         3'b000, 3'b001, 3'b111: begin
            c = dflt();
            if (op == 3'b001) begin c.alu_src = 1'b1; c.alu_opcode = 2'b10; c.sign_or_zero = 1'b0; end
            if (op == 3'b111) begin c.alu_src = 1'b1; c.alu_opcode = 2'b11; end
            push({tag, " exec"}, c, 2, 2);
            c = dflt(); c.reg_wr = 1'b1; c.instr_done = 1'b1;
            c.dest_reg = (op == 3'b000) ? 2'b01 : 2'b00;
            push({tag, " wb_alu"}, c, 2, 2);
         end
         3'b100, 3'b101: begin
            c = dflt(); c.alu_src = 1'b1; c.alu_opcode = 2'b11;
            push({tag, " mem_addr"}, c, 2, 2);
            for (int i = 0; i <= dw; i++) begin
               c = dflt();
               if (op == 3'b100) c.dmem_rd = 1'b1;
               else begin c.dmem_wr = 1'b1; c.instr_done = (i == dw); end
               push({tag, " mem"}, c, 2, (i == dw) ? 1 : 0);
            end
            if (op == 3'b100) begin
               c = dflt(); c.reg_wr = 1'b1; c.mem_to_reg = 2'b01; c.instr_done = 1'b1;
               push({tag, " wb_mem"}, c, 2, 2);
            end
         end
         3'b110: begin
            c = dflt(); c.alu_opcode = 2'b01; c.pc_src = 2'b01; c.pc_wr = z[0]; c.instr_done = 1'b1;
            push({tag, " branch"}, c, 2, 2, z);
         end
         3'b010: begin
            c = dflt(); c.pc_wr = 1'b1; c.pc_src = 2'b10; c.instr_done = 1'b1;
            push({tag, " jump"}, c, 2, 2);
         end
         default: begin
            c = dflt(); c.reg_wr = 1'b1; c.dest_reg = 2'b10; c.mem_to_reg = 2'b10;
            c.pc_wr = 1'b1; c.pc_src = 2'b10; c.instr_done = 1'b1;
            push({tag, " jal"}, c, 2, 2);
         end
      endcase
      model_cnt = (model_cnt + 1) % (1 << CNT_W);
   endtask

   task automatic drain();
      ent_t e;
      ctl_t a;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         rst            = e.rst;
         bus.imem_ready = (e.ir == 2) ? 1'($urandom_range(0, 1)) : 1'(e.ir);
         bus.dmem_ready = (e.dr == 2) ? 1'($urandom_range(0, 1)) : 1'(e.dr);
         bus.alu_zero   = (e.z == 2)  ? 1'($urandom_range(0, 1)) : 1'(e.z);
         bus.cpu_opcode = e.op_fix ? e.op : 3'($urandom_range(0, 7));
         #1;
         a = sample();
         checks++;
         if (a !== e.exp || (e.cnt >= 0 && bus.instr_count !== CNT_W'(e.cnt))) begin
            errors++;
            $display("FAIL %s: got ctl=%b count=%0d, expected ctl=%b count=%0d",
                     e.name, a, bus.instr_count, e.exp, e.cnt);
         end
      end
   endtask

   task automatic test_reset();
      push_reset(3);
      drain();
   endtask

   task automatic test_alu_ops();
      push_instr("add", 3'b000, 0, 0);
      push_instr("sli", 3'b001, 2, 0);
      push_instr("addi", 3'b111, 0, 0);
      drain();
   endtask

   task automatic test_load_store();
      push_instr("lw3", 3'b100, 0, 3);
      push_instr("sw0", 3'b101, 0, 0);
      push_instr("sw5", 3'b101, 1, 5);
      push_instr("lw0", 3'b100, 0, 0);
      drain();
   endtask

   task automatic test_branch();
      push_instr("beq-taken", 3'b110, 0, 0, 1);
      push_instr("beq-not", 3'b110, 0, 0, 0);
      drain();
   endtask

   task automatic test_jumps();
      push_instr("jal", 3'b011, 0, 0);
      push_instr("j", 3'b010, 1, 0);
      drain();
   endtask

   // Ready arriving on the cycle the wait count reaches the limit completes normally.
   task automatic test_timeout_edges();
      push_instr("lw-edge", 3'b100, 0, MEM_TIMEOUT);
      push_instr("sw-edge", 3'b101, 0, MEM_TIMEOUT);
      push_instr("addi-edge", 3'b111, MEM_TIMEOUT, 0);
      drain();
   endtask

   task automatic test_timeout();
      ctl_t c;
      cur_op = 3'b000;
      for (int i = 0; i <= MEM_TIMEOUT; i++) begin
         c = dflt(); c.imem_rd = 1'b1;
         push("timeout wait", c, 0, 2);
      end
      for (int i = 0; i < 4; i++) begin
         c = dflt(); c.fault = 1'b1;
         push("fault sticky", c, 2, 2);
      end
      push_reset(2);
      push_instr("add after fault", 3'b000, 0, 0);
      drain();
   endtask

   task automatic test_wrap();
      push_reset(1);
      for (int i = 0; i < 16; i++) push_instr("j-wrap", 3'b010, 0, 0);
      push_instr("add post-wrap", 3'b000, 0, 0);
      drain();
   endtask

   task automatic test_reset_mid_write();
      ctl_t c;
      cur_op = 3'b101;
      push_fetch("sw-abort", 0);
      c = dflt(); c.alu_src = 1'b1; c.alu_opcode = 2'b11;
      push("sw-abort mem_addr", c, 2, 2);
      for (int i = 0; i < 2; i++) begin
         c = dflt(); c.dmem_wr = 1'b1;
         push("sw-abort mem_wr", c, 2, 0);
      end
      push_reset(2, 1);
      push_instr("j after abort", 3'b010, 0, 0);
      drain();
   endtask

   initial begin
      bus.cpu_opcode = 3'b000;
      bus.alu_zero   = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      test_reset();
      test_alu_ops();
      test_load_store();
      test_branch();
      test_jumps();
      test_timeout_edges();
      test_timeout();
      test_wrap();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
